// File: rtl/sig_gen_if.sv
// Request/status bus between a stimulus controller and sig_gen: a frequency
// request with its load strobe, and the conversion status coming back.
interface sig_gen_if;
    logic [10:0] freq;
    logic        load;
    logic        busy;
    logic [10:0] freq_act;

    modport master (output freq, output load, input busy, input freq_act);
    modport slave  (input freq, input load, output busy, output freq_act);
endinterface

// File: rtl/sig_gen.sv
// Frequency-meter stimulus: a 1 Hz reference gate plus a programmable square wave
// whose half-period comes from a 23-step restoring shift-subtract divider.
module sig_gen #(
    parameter int CLK_HZ = 16_000_000,
    parameter int F_MAX  = 2047
) (
    input  logic     clk_16MHZ,
    input  logic     rst,
    sig_gen_if.slave bus,
    output logic     sig_1HZ,
    output logic     sig_KHZ
);
    localparam logic [22:0] DIVIDEND = 23'(CLK_HZ / 2);
    localparam logic [22:0] TERM_1HZ = 23'(CLK_HZ / 2 - 1);
    localparam logic [10:0] F_LIM    = 11'(F_MAX);

    typedef enum logic [1:0] {IDLE, DIV, APPLY} state_t;

    state_t      state, state_nxt;
    logic [10:0] f_q, f_nxt;
    logic [10:0] rem_q, rem_nxt;
    logic [11:0] rem_sh;
    logic [22:0] quo_q, quo_nxt;
    logic [4:0]  idx_q, idx_nxt;
    logic [22:0] half_pend, half_pend_nxt;
    logic [10:0] freq_act_q, freq_act_nxt;
    logic [22:0] cnt_1hz;
    logic [22:0] tc;
    logic [22:0] half_act;

    // NOTE: state elements use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_16MHZ or negedge rst) begin
        if (!rst) begin
            cnt_1hz <= '0;
            sig_1HZ <= 1'b0;
        end else if (cnt_1hz == TERM_1HZ) begin
            cnt_1hz <= '0;
            sig_1HZ <= ~sig_1HZ;
        end else begin
            cnt_1hz <= cnt_1hz + 23'd1;
        end
    end

    always_ff @(posedge clk_16MHZ or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            f_q        <= '0;
            rem_q      <= '0;
            quo_q      <= '0;
            idx_q      <= '0;
            half_pend  <= '0;
            freq_act_q <= '0;
        end else begin
            state      <= state_nxt;
            f_q        <= f_nxt;
            rem_q      <= rem_nxt;
            quo_q      <= quo_nxt;
            idx_q      <= idx_nxt;
            half_pend  <= half_pend_nxt;
            freq_act_q <= freq_act_nxt;
        end
    end

    // NOTE: every signal written here gets a default first, so no path infers a latch.
    always_comb begin
        state_nxt     = state;
        f_nxt         = f_q;
        rem_nxt       = rem_q;
        quo_nxt       = quo_q;
        idx_nxt       = idx_q;
        half_pend_nxt = half_pend;
        freq_act_nxt  = freq_act_q;
        rem_sh        = {rem_q, DIVIDEND[idx_q]};
        case (state)
            IDLE: begin
                if (bus.load) begin
                    f_nxt     = (bus.freq > F_LIM) ? F_LIM : bus.freq;
                    rem_nxt   = '0;
                    quo_nxt   = '0;
                    idx_nxt   = 5'd22;
                    state_nxt = DIV;
                end
            end
            DIV: begin
                // Partial remainder stays below f, so 11 bits plus the shifted-in bit suffice.
                if (f_q == '0) begin
                    quo_nxt = '0;
                end else if (rem_sh >= {1'b0, f_q}) begin
                    rem_nxt        = 11'(rem_sh - {1'b0, f_q});
                    quo_nxt[idx_q] = 1'b1;
                end else begin
                    rem_nxt = rem_sh[10:0];
                end
                if (idx_q == '0) state_nxt = APPLY;
                else             idx_nxt   = idx_q - 5'd1;
            end
            APPLY: begin
                half_pend_nxt = quo_q;
                freq_act_nxt  = f_q;
                state_nxt     = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign bus.busy     = (state != IDLE);
    assign bus.freq_act = freq_act_q;

    // A new half-period is only picked up at a terminal count, so no phase is ever cut short.
    always_ff @(posedge clk_16MHZ or negedge rst) begin
        if (!rst) begin
            tc       <= '0;
            half_act <= '0;
            sig_KHZ  <= 1'b0;
        end else if (half_act == '0) begin
            tc       <= '0;
            sig_KHZ  <= 1'b0;
            half_act <= half_pend;
        end else if (tc == half_act - 23'd1) begin
            tc       <= '0;
            half_act <= half_pend;
            sig_KHZ  <= (half_pend != '0) ? ~sig_KHZ : 1'b0;
        end else begin
            tc <= tc + 23'd1;
        end
    end
endmodule

// File: tb/tb_sig_gen.sv
// Bench for sig_gen on a scaled clock: table of requests scored through a queue,
// plus hand sequences for mid-phase changes, stopping, and reset during division.
module tb_sig_gen;
    localparam int          CLK_HZ = 32_000;
    localparam int          F_MAX  = 2000;
    localparam int unsigned H1     = CLK_HZ / 2;
    localparam int          BUDGET = 20_000;

    typedef struct {int unsigned freq; int unsigned exp_act; int unsigned exp_half;} vec_t;
    typedef struct {int unsigned act; int unsigned half;} exp_t;
    typedef struct {int unsigned t; logic lvl;} edge_t;

    logic clk_16MHZ = 1'b0;
    logic rst       = 1'b0;
    logic sig_1HZ;
    logic sig_KHZ;

    sig_gen_if bus ();

    sig_gen #(.CLK_HZ(CLK_HZ), .F_MAX(F_MAX)) dut (
        .clk_16MHZ (clk_16MHZ),
        .rst       (rst),
        .bus       (bus),
        .sig_1HZ   (sig_1HZ),
        .sig_KHZ   (sig_KHZ)
    );

    always #5 clk_16MHZ = ~clk_16MHZ;

    int unsigned cyc = 0;
    int          n_pass = 0;
    int          n_total = 0;
    edge_t       kq[$];
    exp_t        sb[$];
    edge_t       got[3];
    exp_t        cur;
    logic        k_prev = 1'b0;
    logic        h_prev = 1'b0;
    int unsigned n1hz = 0;

    always @(posedge clk_16MHZ or negedge rst) begin
        if (!rst) cyc <= 0;
        else      cyc <= cyc + 1;
    end

    task automatic check(input string name, input longint act, input longint exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    // Edge recorder for sig_KHZ and timing checker for sig_1HZ, sampled on the falling clock.
    always @(negedge clk_16MHZ) begin
        if (!rst) begin
            k_prev = 1'b0;
            h_prev = 1'b0;
            n1hz   = 0;
        end else begin
            if (sig_KHZ !== k_prev) begin
                kq.push_back('{cyc, sig_KHZ});
                k_prev = sig_KHZ;
            end
            if (sig_1HZ !== h_prev) begin
                n1hz++;
                check("1hz_edge_time", cyc, n1hz * H1);
                check("1hz_level", sig_1HZ, n1hz % 2);
                h_prev = sig_1HZ;
            end
        end
    end

    task automatic do_load(input int unsigned f, output int unsigned t);
        @(negedge clk_16MHZ);
        bus.freq = 11'(f);
        bus.load = 1'b1;
        @(negedge clk_16MHZ);
        bus.load = 1'b0;
        t = cyc;
    endtask

    task automatic wait_idle(input int budget, output int unsigned t_idle);
        int n = 0;
        while (bus.busy !== 1'b0 && n < budget) begin
            @(negedge clk_16MHZ);
            n++;
        end
        t_idle = cyc;
    endtask

    task automatic pop_and_check(input string name);
        if (sb.size() > 0) cur = sb.pop_front();
        check(name, bus.freq_act, cur.act);
    endtask

    task automatic edges_after(input int unsigned t0, input int need, input int budget, output bit ok);
        int n = 0;
        ok = 1'b0;
        while (!ok && n < budget) begin
            while (kq.size() > 0 && kq[0].t <= t0) void'(kq.pop_front());
            if (kq.size() >= need) ok = 1'b1;
            else begin
                @(negedge clk_16MHZ);
                n++;
            end
        end
        for (int i = 0; i < 3; i++) begin
            if (i < kq.size()) got[i] = kq[i];
            else got[i] = '{0, 1'b0};
        end
    endtask

    task automatic wait_rise(input int budget, output int unsigned t_rise, output bit ok);
        int   n = 0;
        logic prev;
        prev = sig_KHZ;
        ok   = 1'b0;
        while (!ok && n < budget) begin
            @(negedge clk_16MHZ);
            n++;
            if (!prev && sig_KHZ) ok = 1'b1;
            prev = sig_KHZ;
        end
        t_rise = cyc;
    endtask

    initial begin
        #1_500_000;
        $display("FAIL watchdog: got no completion, required finish within 150000 cycles");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vec_t        vecs[6];
        int unsigned t, t2, ti, r;
        bit          ok;

        vecs[0] = '{1000, 1000, 16};
        vecs[1] = '{3,    3,    5333};
        vecs[2] = '{2047, 2000, 8};
        vecs[3] = '{37,   37,   432};
        vecs[4] = '{2000, 2000, 8};
        vecs[5] = '{100,  100,  160};

        bus.freq = '0;
        bus.load = 1'b0;
        repeat (3) @(negedge clk_16MHZ);
        check("rst_sig_1HZ", sig_1HZ, 0);
        check("rst_sig_KHZ", sig_KHZ, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_freq_act", bus.freq_act, 0);
        rst = 1'b1;
        repeat (50) @(negedge clk_16MHZ);
        check("noload_sig_KHZ", sig_KHZ, 0);
        check("noload_busy", bus.busy, 0);
        check("noload_freq_act", bus.freq_act, 0);

        // Each request is applied while the previous tone is still running.
        for (int i = 0; i < 6; i++) begin
            kq.delete();
            do_load(vecs[i].freq, t);
            sb.push_back('{vecs[i].exp_act, vecs[i].exp_half});
            wait_idle(100, ti);
            check($sformatf("v%0d_busy_len", i), ti - t, 24);
            pop_and_check($sformatf("v%0d_freq_act", i));
            edges_after(t + 24, 3, BUDGET, ok);
            check($sformatf("v%0d_edges_seen", i), ok, 1);
            if (i == 0) begin
                check("v0_first_rise_time", got[0].t, t + 25 + cur.half);
                check("v0_first_rise_lvl", got[0].lvl, 1);
            end
            check($sformatf("v%0d_half_a", i), got[1].t - got[0].t, cur.half);
            check($sformatf("v%0d_half_b", i), got[2].t - got[1].t, cur.half);
        end

        // 100 -> 50 during a high phase; a second load while busy is dropped.
        wait_rise(1000, r, ok);
        check("chg_rise_seen", ok, 1);
        kq.delete();
        repeat (20) @(negedge clk_16MHZ);
        do_load(50, t);
        sb.push_back('{50, 320});
        repeat (5) @(negedge clk_16MHZ);
        do_load(7, t2);
        check("chg_busy_at_2nd_load", bus.busy, 1);
        wait_idle(100, ti);
        check("chg_busy_len", ti - t, 24);
        pop_and_check("chg_freq_act");
        edges_after(r, 3, BUDGET, ok);
        check("chg_edges_seen", ok, 1);
        check("chg_old_high_end", got[0].t, r + 160);
        check("chg_old_high_lvl", got[0].lvl, 0);
        check("chg_new_half_a", got[1].t - got[0].t, cur.half);
        check("chg_new_half_b", got[2].t - got[1].t, cur.half);
        repeat (30) @(negedge clk_16MHZ);
        check("chg_ignored_busy", bus.busy, 0);
        check("chg_ignored_freq_act", bus.freq_act, 50);

        // Stop with freq=0 during a high phase.
        wait_rise(1000, r, ok);
        check("stop_rise_seen", ok, 1);
        kq.delete();
        repeat (10) @(negedge clk_16MHZ);
        do_load(0, t);
        sb.push_back('{0, 0});
        wait_idle(100, ti);
        check("stop_busy_len", ti - t, 24);
        pop_and_check("stop_freq_act");
        edges_after(r, 1, BUDGET, ok);
        check("stop_edge_seen", ok, 1);
        check("stop_phase_end", got[0].t, r + 320);
        check("stop_phase_lvl", got[0].lvl, 0);
        void'(kq.pop_front());
        repeat (1000) @(negedge clk_16MHZ);
        check("stop_quiet_edges", kq.size(), 0);
        check("stop_sig_KHZ", sig_KHZ, 0);

        // Restart from stopped; 2047 clamps to the bench's F_MAX.
        kq.delete();
        do_load(2047, t);
        sb.push_back('{2000, 8});
        wait_idle(100, ti);
        check("restart_busy_len", ti - t, 24);
        pop_and_check("restart_freq_act");
        edges_after(t + 24, 3, BUDGET, ok);
        check("restart_edges_seen", ok, 1);
        check("restart_first_rise", got[0].t, t + 25 + cur.half);
        check("restart_half_a", got[1].t - got[0].t, cur.half);
        check("restart_half_b", got[2].t - got[1].t, cur.half);

        begin
            int n = 0;
            while (n1hz < 3 && n < 60_000) begin
                @(negedge clk_16MHZ);
                n++;
            end
        end
        check("1hz_three_edges", n1hz >= 3, 1);

        // Reset pulsed in the middle of a division.
        do_load(1000, t);
        repeat (5) @(negedge clk_16MHZ);
        check("rstdiv_busy_before", bus.busy, 1);
        #2 rst = 1'b0;
        #1;
        check("rstdiv_busy", bus.busy, 0);
        check("rstdiv_freq_act", bus.freq_act, 0);
        check("rstdiv_sig_KHZ", sig_KHZ, 0);
        check("rstdiv_sig_1HZ", sig_1HZ, 0);
        repeat (3) @(negedge clk_16MHZ);
        rst = 1'b1;
        kq.delete();
        repeat (100) @(negedge clk_16MHZ);
        check("rstdiv_after_busy", bus.busy, 0);
        check("rstdiv_after_freq_act", bus.freq_act, 0);
        check("rstdiv_after_sig_KHZ", sig_KHZ, 0);
        check("rstdiv_after_edges", kq.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
